// File: rtl/watch_dp.sv
// watch_dp: centisecond time-of-day datapath with a clock-cycle timebase,
// cascaded ms/sec/min/hour counters and per-field up/down adjustment.
module watch_dp #(
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_digit_pos,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_run,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_tick
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [6:0]       MSEC_LAST = 7'd99;
    localparam logic [5:0]       SIX_LAST  = 6'd59;
    localparam logic [4:0]       HOUR_LAST = 5'(HOUR_MAX);

    logic [DIV_W-1:0] div_q;

    logic       adj_ok;
    logic       sel_sec;
    logic       sel_min;
    logic       sel_hour;
    logic [6:0] msec_n;
    logic [5:0] sec_n;
    logic [5:0] min_n;
    logic [4:0] hour_n;
    logic       msec_carry;
    logic       sec_carry;
    logic       min_carry;

    // Adjust is accepted only for exactly one of up/down and a one-hot field select.
    assign adj_ok   = i_up ^ i_down;
    assign sel_sec  = adj_ok && (i_digit_pos == 3'b001);
    assign sel_min  = adj_ok && (i_digit_pos == 3'b010);
    assign sel_hour = adj_ok && (i_digit_pos == 3'b100);

    // Timebase divider; holds its count while stopped and pulses o_tick on wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q  <= '0;
            o_tick <= 1'b0;
        end else if (i_run) begin
            if (div_q == DIV_LAST) begin
                div_q  <= '0;
                o_tick <= 1'b1;
            end else begin
                div_q  <= div_q + DIV_W'(1);
                o_tick <= 1'b0;
            end
        end else begin
            o_tick <= 1'b0;
        end
    end

    // Next field values: tick cascade, with an adjusted field taking the adjust
    // and swallowing both its incoming carry and its own outgoing carry.
    always_comb begin
        msec_n     = o_msec;
        sec_n      = o_sec;
        min_n      = o_min;
        hour_n     = o_hour;
        msec_carry = 1'b0;
        sec_carry  = 1'b0;
        min_carry  = 1'b0;

        if (o_tick) begin
            if (o_msec >= MSEC_LAST) begin
                msec_n     = '0;
                msec_carry = 1'b1;
            end else begin
                msec_n = o_msec + 7'd1;
            end
        end

        if (sel_sec) begin
            if (i_up) sec_n = (o_sec >= SIX_LAST) ? 6'd0 : o_sec + 6'd1;
            else      sec_n = (o_sec == 6'd0) ? SIX_LAST : o_sec - 6'd1;
        end else if (msec_carry) begin
            if (o_sec >= SIX_LAST) begin
                sec_n     = '0;
                sec_carry = 1'b1;
            end else begin
                sec_n = o_sec + 6'd1;
            end
        end

        if (sel_min) begin
            if (i_up) min_n = (o_min >= SIX_LAST) ? 6'd0 : o_min + 6'd1;
            else      min_n = (o_min == 6'd0) ? SIX_LAST : o_min - 6'd1;
        end else if (sec_carry) begin
            if (o_min >= SIX_LAST) begin
                min_n     = '0;
                min_carry = 1'b1;
            end else begin
                min_n = o_min + 6'd1;
            end
        end

        if (sel_hour) begin
            if (i_up) hour_n = (o_hour >= HOUR_LAST) ? 5'd0 : o_hour + 5'd1;
            else      hour_n = (o_hour == 5'd0) ? HOUR_LAST : o_hour - 5'd1;
        end else if (min_carry) begin
            hour_n = (o_hour >= HOUR_LAST) ? 5'd0 : o_hour + 5'd1;
        end
    end

    // Time field registers; reset overrides any tick or adjust in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_msec <= '0;
            o_sec  <= '0;
            o_min  <= '0;
            o_hour <= '0;
        end else begin
            o_msec <= msec_n;
            o_sec  <= sec_n;
            o_min  <= min_n;
            o_hour <= hour_n;
        end
    end

endmodule

// File: tb/tb_watch_dp.sv
// tb_watch_dp: directed scenarios plus random stimulus against a
// total-centisecond reference model of the watch datapath.
module tb_watch_dp;

    localparam int TD = 4;
    localparam int HM = 23;

    logic       clk;
    logic       rst;
    logic [2:0] i_digit_pos;
    logic       i_up;
    logic       i_down;
    logic       i_run;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_tick;

    int n_vec;
    int n_err;

    // reference model state
    int m_div, m_tick, m_ms, m_s, m_m, m_h;

    watch_dp #(.TICK_DIV(TD), .HOUR_MAX(HM)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_digit_pos (i_digit_pos),
        .i_up        (i_up),
        .i_down      (i_down),
        .i_run       (i_run),
        .o_msec      (o_msec),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_hour      (o_hour),
        .o_tick      (o_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int h, input int m, input int s, input int ms);
        return 32'((h << 19) | (m << 13) | (s << 7) | ms);
    endfunction

    function automatic logic [31:0] dut_pack();
        return 32'({o_hour, o_min, o_sec, o_msec});
    endfunction

    function automatic logic [31:0] model_pack();
        return pack(m_h, m_m, m_s, m_ms);
    endfunction

    // Model one clock edge: time kept as a single centisecond count, adjust
    // overrides one field and freezes every field above it.
    task automatic model_edge();
        int total, c_ms, c_s, c_m, c_h, delta;
        bit legal;
        if (!rst) begin
            m_div = 0; m_tick = 0; m_ms = 0; m_s = 0; m_m = 0; m_h = 0;
            return;
        end
        c_ms = m_ms; c_s = m_s; c_m = m_m; c_h = m_h;
        if (m_tick != 0) begin
            total = (((m_h * 60 + m_m) * 60 + m_s) * 100 + m_ms + 1) % ((HM + 1) * 360000);
            c_ms  = total % 100;
            c_s   = (total / 100) % 60;
            c_m   = (total / 6000) % 60;
            c_h   = total / 360000;
        end
        legal = (i_up != i_down) &&
                (i_digit_pos == 3'b001 || i_digit_pos == 3'b010 || i_digit_pos == 3'b100);
        delta = i_up ? 1 : -1;
        if (legal) begin
            if (i_digit_pos == 3'b001) begin
                c_s = (m_s + delta + 60) % 60; c_m = m_m; c_h = m_h;
            end else if (i_digit_pos == 3'b010) begin
                c_m = (m_m + delta + 60) % 60; c_h = m_h;
            end else begin
                c_h = (m_h + delta + HM + 1) % (HM + 1);
            end
        end
        m_ms = c_ms; m_s = c_s; m_m = c_m; m_h = c_h;
        if (i_run) begin
            m_tick = (m_div == TD - 1) ? 1 : 0;
            m_div  = (m_div == TD - 1) ? 0 : m_div + 1;
        end else begin
            m_tick = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("tick", 32'(o_tick), 32'(m_tick));
        check("time", dut_pack(), model_pack());
    endtask

    task automatic adj(input logic [2:0] pos, input logic up);
        i_digit_pos = pos;
        i_up        = up;
        i_down      = !up;
        step();
        i_up   = 1'b0;
        i_down = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        i_run = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic run_until_msec99();
        int n;
        n = 0;
        i_run = 1'b1;
        while (o_msec != 7'd99 && n < 600) begin
            step();
            n++;
        end
        if (n >= 600) check("msec99_timeout", 32'(o_msec), 32'd99);
        i_run = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (o_tick != 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("tick_timeout", 32'(o_tick), 32'd1);
    endtask

    logic [31:0] snap;

    initial begin
        n_vec = 0; n_err = 0;
        m_div = 0; m_tick = 0; m_ms = 0; m_s = 0; m_m = 0; m_h = 0;
        rst = 1'b0; i_run = 1'b0; i_up = 1'b0; i_down = 1'b0; i_digit_pos = 3'b000;

        // reset state
        step();
        step();
        check("reset_time", dut_pack(), 32'd0);
        check("reset_tick", 32'(o_tick), 32'd0);

        // free run from reset release
        rst   = 1'b1;
        i_run = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("first_msec", 32'(o_msec), 32'd1);
        for (int i = 0; i < 396; i++) step();
        check("sec_after_100", 32'({o_sec, o_msec}), 32'(1 << 7));

        // tick/adjust collision on the seconds field
        do_reset();
        run_until_msec99();
        for (int i = 0; i < 10; i++) adj(3'b001, 1'b1);
        check("coll_pre", 32'({o_sec, o_msec}), 32'((10 << 7) | 99));
        i_run = 1'b1;
        wait_tick();
        adj(3'b001, 1'b1);
        check("coll_post", dut_pack(), pack(0, 0, 11, 0));

        // full rollover 23:59:59.99 -> 0
        do_reset();
        run_until_msec99();
        adj(3'b100, 1'b0);
        adj(3'b010, 1'b0);
        adj(3'b001, 1'b0);
        check("roll_pre", dut_pack(), pack(23, 59, 59, 99));
        i_run = 1'b1;
        wait_tick();
        step();
        check("roll_post", dut_pack(), 32'd0);

        // adjust wrap on minutes, no carry or borrow into hours
        do_reset();
        adj(3'b010, 1'b0);
        check("min_down_wrap", 32'(o_min), 32'd59);
        adj(3'b010, 1'b1);
        check("min_up_wrap", 32'({o_hour, o_min}), 32'd0);
        adj(3'b010, 1'b0);

        // illegal adjust inputs
        i_digit_pos = 3'b010; i_up = 1'b1; i_down = 1'b1;
        step();
        i_up = 1'b0; i_down = 1'b0;
        check("both_pressed", dut_pack(), pack(0, 59, 0, 0));
        adj(3'b011, 1'b1);
        check("not_onehot", dut_pack(), pack(0, 59, 0, 0));

        // freeze then reset mid-run
        i_run = 1'b1;
        for (int i = 0; i < 37; i++) step();
        i_run = 1'b0;
        step();
        snap = model_pack();
        for (int i = 0; i < 20; i++) begin
            step();
            check("frozen_time", dut_pack(), snap);
            check("frozen_tick", 32'(o_tick), 32'd0);
        end
        i_run = 1'b1;
        for (int i = 0; i < 6; i++) step();
        rst = 1'b0;
        step();
        check("midrun_reset", dut_pack(), 32'd0);
        rst = 1'b1;

        // random stimulus
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 399) != 0);
            i_run = ($urandom_range(0, 7) != 0);
            i_up  = ($urandom_range(0, 5) == 0);
            i_down = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 0) i_digit_pos = 3'(1 << $urandom_range(0, 2));
            else                           i_digit_pos = 3'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/watch_dp.md
WATCH_DP -- requirements
Module: watch_dp

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 1_000_000, clk cycles per 10 ms tick (100 MHz -> 100 Hz); legal range 2..2^24.
REQ-002 SHALL provide parameter HOUR_MAX, default 23, the largest hour value before wrap to 0.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-low.
REQ-005 SHALL have port i_digit_pos  input  3  one-hot field select from control unit: 001=sec, 010=min, 100=hour.
REQ-006 SHALL have port i_up  input  1  single-cycle pulse, increment selected field.
REQ-007 SHALL have port i_down  input  1  single-cycle pulse, decrement selected field.
REQ-008 SHALL have port i_run  input  1  1 = time advances, 0 = timebase frozen.
REQ-009 SHALL have port o_msec  output  7  centiseconds, 0..99.
REQ-010 SHALL have port o_sec  output  6  seconds, 0..59.
REQ-011 SHALL have port o_min  output  6  minutes, 0..59.
REQ-012 SHALL have port o_hour  output  5  hours, 0..HOUR_MAX.
REQ-013 SHALL have port o_tick  output  1  one-cycle pulse on each 10 ms tick.

Function
REQ-014 SHALL count clk cycles in a divider 0..TICK_DIV-1 while i_run=1; at TICK_DIV-1 it wraps to 0 and asserts o_tick for exactly that cycle.
REQ-015 SHALL hold the divider value and suppress o_tick while i_run=0; resuming continues from the held count.
REQ-016 SHALL increment o_msec on the cycle following o_tick; 99 -> 0 generates a carry to o_sec in the same update.
REQ-017 SHALL cascade carries: sec 59->0 carries to min, min 59->0 carries to hour, hour HOUR_MAX->0 with no further carry; all cascaded fields update in the same clock edge.
REQ-018 SHALL register all outputs; counter update latency = 1 cycle from o_tick, adjust latency = 1 cycle from i_up/i_down.
REQ-019 SHALL apply i_up to the field selected by i_digit_pos: +1, max value wraps to 0, no carry into the next field.
REQ-020 SHALL apply i_down to the selected field: -1, 0 wraps to max value (59 or HOUR_MAX), no borrow from the next field.
REQ-021 SHALL ignore adjustment when i_up and i_down are both 1 in the same cycle.
REQ-022 SHALL ignore adjustment when i_digit_pos is not exactly one-hot (000, 011, 101, 110, 111).
REQ-023 SHALL, when an adjust and a tick-cascade update hit the same field in the same cycle, apply only the adjust to that field and discard the incoming carry; other fields update per cascade normally, including carries generated by the adjusted field's old value being bypassed (no carry emitted from an adjusted field).
REQ-024 SHALL accept adjustments regardless of i_run.
REQ-025 SHALL never leave o_msec, o_sec, o_min, o_hour outside their legal ranges.

Reset
REQ-026 SHALL, on rising clk with rst=0, clear divider, o_msec, o_sec, o_min, o_hour, o_tick to 0; reset overrides tick and adjust in that cycle.
REQ-027 SHALL resume counting from divider 0 on the first cycle after rst returns to 1; reset asserted mid-cascade leaves no partial update.

Verification (TICK_DIV=4, HOUR_MAX=23)
REQ-028 SHALL check free run: release reset, i_run=1 -> o_tick every 4th cycle, o_msec=1 after first tick, 100 ticks -> o_sec=1, o_msec=0.
REQ-029 SHALL check full rollover: preload via adjusts to 23:59:59, o_msec=99, next tick -> all fields 0 in one edge.
REQ-030 SHALL check adjust wrap: i_digit_pos=010, o_min=59, i_up -> o_min=0 and o_hour unchanged; o_min=0, i_down -> o_min=59.
REQ-031 SHALL check illegal inputs: i_up=i_down=1 -> no change; i_digit_pos=011 with i_up -> no change.
REQ-032 SHALL check collision: o_sec=10, o_msec=99, i_digit_pos=001, i_up coincident with tick update -> o_sec=11, o_msec=0, o_min unchanged.
REQ-033 SHALL check i_run=0 for 20 cycles -> outputs and o_tick frozen; rst=0 mid-run -> all outputs 0 next edge.
